// File: rtl/game_screen_ctrl_pkg.sv
// Shared types and default parameters for the ping-pong screen/match sequencer.
package pong_pkg;

   typedef enum logic [1:0] {
      TITLE = 2'd0,
      SERVE = 2'd1,
      PLAY  = 2'd2,
      OVER  = 2'd3
   } state_t;

   typedef logic [11:0] color_t;

   localparam int WIN_SCORE_DEF      = 7;
   localparam int SERVE_FRAMES_DEF   = 60;
   localparam int HOLDOFF_FRAMES_DEF = 90;
   localparam int FRAME_LINE_DEF     = 480;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/game_screen_ctrl_if.sv
// Pixel bus between the VGA sync/renderers (master) and the screen controller (slave).
interface game_screen_ctrl_if;
   import pong_pkg::*;

   logic       p_tick;
   logic       video_on;
   logic [9:0] x;
   logic [9:0] y;
   color_t     rgb_title;
   color_t     rgb_play;
   color_t     rgb_over;
   color_t     rgb;

   modport master (output p_tick, video_on, x, y, rgb_title, rgb_play, rgb_over,
                   input  rgb);
   modport slave  (input  p_tick, video_on, x, y, rgb_title, rgb_play, rgb_over,
                   output rgb);
endinterface

// File: rtl/game_screen_ctrl_btn_edge.sv
// Two-flop synchroniser plus rising-edge pulse for one raw button.
module btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);
   logic sync0_r, sync1_r, prev_r;
   logic vld0_r, vld1_r, armed_r;

   // Synchroniser chain; armed_r stays low until a released level is seen, so a
   // button already held when reset drops never fires.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync0_r <= 1'b0;
         sync1_r <= 1'b0;
         prev_r  <= 1'b0;
         vld0_r  <= 1'b0;
         vld1_r  <= 1'b0;
         armed_r <= 1'b0;
      end else begin
         sync0_r <= btn;
         sync1_r <= sync0_r;
         prev_r  <= sync1_r;
         vld0_r  <= 1'b1;
         vld1_r  <= vld0_r;
         armed_r <= armed_r | (vld1_r & ~sync1_r);
      end
   end

   assign pulse = armed_r & sync1_r & ~prev_r;
endmodule

// File: rtl/game_screen_ctrl.sv
// Match sequencer (TITLE/SERVE/PLAY/OVER), scores, game reset pulse and colour mux.
// Optional GAMEOVER_BLINK_EN: blink the game-over overlay every 16 frames.
module game_screen_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE      = WIN_SCORE_DEF,
   parameter int SERVE_FRAMES   = SERVE_FRAMES_DEF,
   parameter int HOLDOFF_FRAMES = HOLDOFF_FRAMES_DEF,
   parameter int FRAME_LINE     = FRAME_LINE_DEF
) (
   input  logic                clk,
   input  logic                reset,
   game_screen_ctrl_if.slave   vid,
   input  logic                enter,
   input  logic                up1,
   input  logic                down1,
   input  logic                up2,
   input  logic                down2,
   input  logic                miss1,
   input  logic                miss2,
   output logic                game_rst,
   output logic                play_en,
   output logic [3:0]          score1,
   output logic [3:0]          score2,
   output logic [1:0]          state
);
   logic [4:0] btn_s;
   logic [4:0] edge_s;
   logic       go_evt_s;
   logic       frame_tick_s;

   state_t     state_r, state_nxt_s;
   logic [3:0] score1_r, score2_r, score1_nxt_s, score2_nxt_s;
   logic       game_rst_r, game_rst_nxt_s, play_en_r;
   logic [7:0] frame_cnt_r;
   color_t     rgb_r, rgb_sel_s;

   assign btn_s = {down2, up2, down1, up1, enter};

   for (genvar i = 0; i < 5; i++) begin : g_btn
      btn_edge u_btn (.clk(clk), .reset(reset), .btn(btn_s[i]), .pulse(edge_s[i]));
   end

   assign go_evt_s     = |edge_s;
   assign frame_tick_s = vid.p_tick && (vid.x == 10'd0) && (vid.y == 10'(FRAME_LINE));

   // Next-state, score update and game_rst request.
   always_comb begin
      state_nxt_s    = state_r;
      score1_nxt_s   = score1_r;
      score2_nxt_s   = score2_r;
      game_rst_nxt_s = 1'b0;
      case (state_r)
         TITLE: begin
            if (go_evt_s) begin
               score1_nxt_s   = 4'd0;
               score2_nxt_s   = 4'd0;
               game_rst_nxt_s = 1'b1;
               state_nxt_s    = SERVE;
            end else begin
               state_nxt_s    = TITLE;
            end
         end
         SERVE: begin
            if (frame_cnt_r == 8'(SERVE_FRAMES)) begin
               state_nxt_s = PLAY;
            end else begin
               state_nxt_s = SERVE;
            end
         end
         PLAY: begin
            score1_nxt_s = miss2 ? sat_inc4(score1_r) : score1_r;
            score2_nxt_s = miss1 ? sat_inc4(score2_r) : score2_r;
            if (miss1 || miss2) begin
               if ((score1_nxt_s >= 4'(WIN_SCORE)) || (score2_nxt_s >= 4'(WIN_SCORE))) begin
                  state_nxt_s = OVER;
               end else begin
                  game_rst_nxt_s = 1'b1;
                  state_nxt_s    = SERVE;
               end
            end else begin
               state_nxt_s = PLAY;
            end
         end
         OVER: begin
            if (go_evt_s && (frame_cnt_r >= 8'(HOLDOFF_FRAMES))) begin
               score1_nxt_s   = 4'd0;
               score2_nxt_s   = 4'd0;
               game_rst_nxt_s = 1'b1;
               state_nxt_s    = SERVE;
            end else begin
               state_nxt_s    = OVER;
            end
         end
         default: begin
            state_nxt_s = TITLE;
         end
      endcase
   end

   // State, scores and control pulses; play_en tracks the registered state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= TITLE;
         score1_r   <= 4'd0;
         score2_r   <= 4'd0;
         game_rst_r <= 1'b0;
         play_en_r  <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         score1_r   <= score1_nxt_s;
         score2_r   <= score2_nxt_s;
         game_rst_r <= game_rst_nxt_s;
         play_en_r  <= (state_nxt_s == PLAY);
      end
   end

   // Frame counter restarts on every state entry and saturates at 255.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_r <= 8'd0;
      end else if (state_nxt_s != state_r) begin
         frame_cnt_r <= 8'd0;
      end else if (frame_tick_s && (frame_cnt_r != 8'hFF)) begin
         frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   // Renderer selection by phase.
   always_comb begin
      rgb_sel_s = 12'h000;
      case (state_r)
         TITLE:       rgb_sel_s = vid.rgb_title;
         SERVE, PLAY: rgb_sel_s = vid.rgb_play;
`ifdef GAMEOVER_BLINK_EN
         OVER:        rgb_sel_s = (frame_cnt_r[4] == 1'b0) ? vid.rgb_over : 12'h000;
`else
         OVER:        rgb_sel_s = vid.rgb_over;
`endif
         default:     rgb_sel_s = 12'h000;
      endcase
   end

   // Output colour register, advanced only on pixel ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_r <= 12'h000;
      end else if (vid.p_tick) begin
         rgb_r <= vid.video_on ? rgb_sel_s : 12'h000;
      end else begin
         rgb_r <= rgb_r;
      end
   end

   assign vid.rgb  = rgb_r;
   assign game_rst = game_rst_r;
   assign play_en  = play_en_r;
   assign score1   = score1_r;
   assign score2   = score2_r;
   assign state    = state_r;
endmodule

// File: tb/tb_game_screen_ctrl.sv
// Scoreboard bench for game_screen_ctrl: expected state/score/game_rst events are
// queued when stimulus is driven and compared when the DUT changes.
module tb_game_screen_ctrl;
   import pong_pkg::*;

   localparam int WIN = 7;
   localparam int SF  = 60;

   typedef struct packed {
      logic [1:0] st;
      logic [3:0] s1;
      logic [3:0] s2;
      logic       rst;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   logic enter, up1, down1, up2, down2, miss1, miss2;
   logic game_rst, play_en;
   logic [3:0] score1, score2;
   logic [1:0] state;

   game_screen_ctrl_if vif ();

   game_screen_ctrl dut (
      .clk(clk), .reset(reset), .vid(vif),
      .enter(enter), .up1(up1), .down1(down1), .up2(up2), .down2(down2),
      .miss1(miss1), .miss2(miss2),
      .game_rst(game_rst), .play_en(play_en),
      .score1(score1), .score2(score2), .state(state)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   ev_t        exp_q[$];
   ev_t        mon_e;
   bit         mon_en   = 1'b0;
   logic [1:0] pst;
   logic [3:0] ps1, ps2;
   int         es1, es2, lat;
   logic [11:0] exp_rgb;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push_ev(input logic [1:0] st, input int s1, input int s2, input logic r);
      ev_t e;
      e.st = st; e.s1 = 4'(s1); e.s2 = 4'(s2); e.rst = r;
      exp_q.push_back(e);
   endtask

   // Event monitor: any game_rst or state/score change pops one expectation.
   always @(negedge clk) begin
      if (mon_en && (game_rst || state != pst || score1 != ps1 || score2 != ps2)) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_event", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("ev_state",    32'(state),    32'(mon_e.st));
            check_eq("ev_score1",   32'(score1),   32'(mon_e.s1));
            check_eq("ev_score2",   32'(score2),   32'(mon_e.s2));
            check_eq("ev_game_rst", 32'(game_rst), 32'(mon_e.rst));
         end
      end
      pst = state; ps1 = score1; ps2 = score2;
   end

   task automatic frame_tick();
      @(negedge clk); vif.p_tick = 1'b1; vif.x = 10'd0; vif.y = 10'd480;
      @(negedge clk); vif.p_tick = 1'b0; vif.x = 10'd5; vif.y = 10'd5;
   endtask

   task automatic pix_tick();
      @(negedge clk); vif.p_tick = 1'b1;
      @(negedge clk); vif.p_tick = 1'b0;
   endtask

   task automatic press(input int which);
      @(negedge clk);
      case (which)
         1: up1 = 1'b1;
         4: down2 = 1'b1;
         default: enter = 1'b1;
      endcase
      repeat (3) @(negedge clk);
      enter = 1'b0; up1 = 1'b0; down2 = 1'b0;
   endtask

   task automatic serve_to_play();
      push_ev(PLAY, es1, es2, 1'b0);
      repeat (SF - 1) frame_tick();
      check_eq("serve_len_state", 32'(state), 32'(SERVE));
      check_eq("serve_play_en", 32'(play_en), 32'd0);
      frame_tick();
      @(negedge clk);
      check_eq("play_state", 32'(state), 32'(PLAY));
      check_eq("play_en", 32'(play_en), 32'd1);
      check_eq("rgb_serve", 32'(vif.rgb), 32'h0F0);
   endtask

   task automatic do_miss(input logic m1, input logic m2);
      int n1, n2;
      n1 = (m2 && es1 < 15) ? es1 + 1 : es1;
      n2 = (m1 && es2 < 15) ? es2 + 1 : es2;
      if (n1 >= WIN || n2 >= WIN) push_ev(OVER, n1, n2, 1'b0);
      else push_ev(SERVE, n1, n2, 1'b1);
      es1 = n1; es2 = n2;
      @(negedge clk); miss1 = m1; miss2 = m2;
      @(negedge clk); miss1 = 1'b0; miss2 = 1'b0;
      check_eq("miss_play_en", 32'(play_en), 32'd0);
      @(negedge clk);
      if (es1 < WIN && es2 < WIN) serve_to_play();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: timeout reached, expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      {enter, up1, down1, up2, down2, miss1, miss2} = 7'd0;
      vif.p_tick = 1'b0; vif.video_on = 1'b0; vif.x = 10'd5; vif.y = 10'd5;
      vif.rgb_title = 12'hF00; vif.rgb_play = 12'h0F0; vif.rgb_over = 12'hFFF;
      es1 = 0; es2 = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_score1", 32'(score1), 32'd0);
      check_eq("rst_score2", 32'(score2), 32'd0);
      check_eq("rst_game_rst", 32'(game_rst), 32'd0);
      check_eq("rst_play_en", 32'(play_en), 32'd0);
      check_eq("rst_rgb", 32'(vif.rgb), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      mon_en = 1'b1;

      // Colour mux in TITLE.
      vif.video_on = 1'b1; pix_tick();
      check_eq("rgb_title", 32'(vif.rgb), 32'hF00);
      vif.video_on = 1'b0; pix_tick();
      check_eq("rgb_blank", 32'(vif.rgb), 32'h000);
      vif.video_on = 1'b1; pix_tick();
      check_eq("rgb_title2", 32'(vif.rgb), 32'hF00);
      vif.rgb_title = 12'h0AB;
      repeat (3) @(negedge clk);
      check_eq("rgb_hold", 32'(vif.rgb), 32'hF00);
      vif.rgb_title = 12'hF00;

      // Start: enter held 3 clk, game_rst at the third edge.
      push_ev(SERVE, 0, 0, 1'b1);
      @(negedge clk); enter = 1'b1; lat = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (game_rst && lat < 0) lat = i;
         if (i == 3) enter = 1'b0;
      end
      check_eq("go_latency", 32'(lat), 32'd3);
      serve_to_play();

      press(4);
      repeat (3) @(negedge clk);
      check_eq("play_ignores_go", 32'(state), 32'(PLAY));

      do_miss(1'b0, 1'b1);
      do_miss(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) do_miss(1'b1, 1'b0);
      // Scores 2/3: miss2 then, during SERVE, a miss1 that must be ignored.
      push_ev(SERVE, 3, 3, 1'b1);
      es1 = 3;
      @(negedge clk); miss2 = 1'b1;
      @(negedge clk); miss2 = 1'b0;
      @(negedge clk); miss1 = 1'b1;
      @(negedge clk); miss1 = 1'b0;
      @(negedge clk);
      check_eq("serve_miss_s2", 32'(score2), 32'd3);
      check_eq("serve_miss_s1", 32'(score1), 32'd3);
      serve_to_play();
      for (int i = 0; i < 3; i++) do_miss(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) do_miss(1'b1, 1'b0);
      do_miss(1'b1, 1'b1);
      check_eq("over_state", 32'(state), 32'(OVER));

      // OVER: blink window, holdoff, restart.
      for (int t = 1; t <= 95; t++) begin
         frame_tick();
         if (t <= 32) begin
`ifdef GAMEOVER_BLINK_EN
            exp_rgb = (((t - 1) & 16) == 0) ? 12'hFFF : 12'h000;
`else
            exp_rgb = 12'hFFF;
`endif
            check_eq($sformatf("rgb_over_f%0d", t - 1), 32'(vif.rgb), 32'(exp_rgb));
         end
         if (t == 10) begin
            press(1);
            repeat (3) @(negedge clk);
            check_eq("holdoff_state", 32'(state), 32'(OVER));
            check_eq("over_hold_s1", 32'(score1), 32'd7);
         end
      end
      push_ev(SERVE, 0, 0, 1'b1);
      es1 = 0; es2 = 0;
      press(1);
      repeat (4) @(negedge clk);
      check_eq("restart_state", 32'(state), 32'(SERVE));

      // Mid-operation reset with enter held across release.
      mon_en = 1'b0;
      @(negedge clk); reset = 1'b1; enter = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("mid_rst_state", 32'(state), 32'd0);
      check_eq("mid_rst_score1", 32'(score1), 32'd0);
      check_eq("mid_rst_rgb", 32'(vif.rgb), 32'd0);
      check_eq("mid_rst_play_en", 32'(play_en), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (8) @(negedge clk);
      enter = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("held_btn_no_go", 32'(state), 32'd0);
      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
